pwm_shadow_loader: RTL and testbench
====================================

PWM_SHADOW_LOADER -- requirements
Module: pwm_shadow_loader

Interface
REQ-001 SHALL have parameter PERIOD_RST, 32'd999, period value after reset.
REQ-002 SHALL have parameter DT_RST, 32'd10, dead_time value after reset.
REQ-003 SHALL have parameter DT_MAX, 32'd255, upper clamp for dead_time.
REQ-004 SHALL have parameter PERIOD_MIN, 32'd16; any smaller requested period is rejected.
REQ-005 Ports, in this order:
  clk  in  1  clock
  rstn  in  1  synchronous, active-low reset
  s_valid  in  1  new set-point offered
  s_ready  out  1  set-point can be accepted
  s_period  in  32  requested carrier period
  s_duty  in  32  requested duty compare value
  s_dead_time  in  32  requested dead time
  step_max  in  32  max duty change per carrier boundary; 0 = unlimited
  force_load  in  1  apply pending target fully at next clock
  slope  in  1  carrier mode, 0 sawtooth, 1 triangular
  f_zero  in  1  carrier counter == 0 (level)
  f_period  in  1  carrier counter == period (level)
  period  out  32  active period to modulator
  duty_cycle  out  32  active duty to modulator
  dead_time  out  32  active dead time to modulator
  loaded  out  1  one-cycle pulse: target fully applied
  clamped  out  1  sticky: last accepted set-point was clamped
  rejected  out  1  one-cycle pulse: set-point refused

Function
REQ-006 Sync event ev SHALL be the rising edge of f_zero, or of f_period when slope=1; f_zero/f_period registered once for edge detection; level hold of several cycles yields one ev.
REQ-007 States SHALL be IDLE, PENDING, SLEW; s_ready=1 only in IDLE.
REQ-008 Handshake: transfer when s_valid && s_ready at a clock edge; s_* captured into shadow registers on that edge.
REQ-009 On transfer with s_period < PERIOD_MIN: shadow unchanged, rejected pulses next cycle, state stays IDLE.
REQ-010 On valid transfer: target_duty = min(s_duty, s_period), target_dt = min(s_dead_time, DT_MAX); clamped set if either clamp active, cleared otherwise; state -> PENDING.
REQ-011 A transfer on the same edge as ev SHALL NOT be applied on that ev; it waits for the next ev.
REQ-012 In PENDING on ev: period <= target_period and dead_time <= target_dt on that edge (visible next cycle).
REQ-013 Duty on ev: if step_max==0 or |target-duty_cycle| <= step_max, duty_cycle <= target, loaded pulses, -> IDLE; else duty_cycle moves step_max toward target, -> SLEW.
REQ-014 In SLEW, each ev applies REQ-013 rule again until target reached.
REQ-015 Difference SHALL be computed as unsigned subtraction of larger minus smaller; no wrap-around, never overshoot target.
REQ-016 force_load high in PENDING or SLEW: next edge loads all targets, loaded pulses, -> IDLE; ignored in IDLE; force_load with simultaneous ev behaves as force_load.
REQ-017 step_max SHALL be sampled at each ev, so changes take effect at the next boundary.
REQ-018 Outputs SHALL be registered; loaded and rejected high exactly one cycle.

Reset
REQ-019 rstn low at any clock edge: state IDLE, period=PERIOD_RST, duty_cycle=0, dead_time=DT_RST, loaded=0, rejected=0, clamped=0, edge registers=0, shadow=reset values; s_ready=1 the cycle after rstn rises.
REQ-020 Reset mid-PENDING/SLEW SHALL discard the pending target.

Structure
REQ-021 Shared package pwm_pkg SHALL hold state encodings (IDLE, PENDING, SLEW) and PWM_W=32.
REQ-022 One sub-module carrier_event_detect SHALL produce ev from f_zero, f_period, slope.

Verification
REQ-023 Reset: after rstn release, period=999, duty_cycle=0, dead_time=10, s_ready=1.
REQ-024 Step load, sawtooth: send period 1000, duty 400, dt 20, step_max 0 -> outputs unchanged until next f_zero rise, then 1000/400/20, loaded one cycle, s_ready back to 1.
REQ-025 Slew: duty 100 -> target 450, step_max 100, triangular -> duty_cycle 200,300,400,450 on successive f_zero/f_period edges; loaded only with 450.
REQ-026 Clamp: period 500, duty 800, dt 300 -> duty 500, dt 255, clamped=1; next request in range clears clamped.
REQ-027 Reject: period 8 -> rejected one cycle, state IDLE, outputs unchanged.
REQ-028 force_load during SLEW at duty 200 toward 450 -> duty 450 next cycle, loaded, IDLE; f_zero held 2 cycles yields single step.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM shadow loader.
package pwm_pkg;

  localparam int unsigned PWM_W = 32;

  typedef logic [PWM_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SLEW    = 2'd2
  } state_t;

  // Shadow set-point held between handshake and carrier boundary.
  typedef struct packed {
    word_t period;
    word_t duty;
    word_t dt;
  } setpoint_t;

  // One slew step toward tgt; step of zero means jump straight to target.
  function automatic word_t slew_step(word_t cur, word_t tgt, word_t step);
    word_t diff;
    diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    if ((step == '0) || (diff <= step)) begin
      return tgt;
    end else if (tgt > cur) begin
      return cur + step;
    end else begin
      return cur - step;
    end
  endfunction

endpackage

// File: rtl/pwm_shadow_loader_carrier_event_detect.sv
// Carrier boundary detector: rising edge of f_zero, or of f_period in triangular mode.
module carrier_event_detect (
  input  logic clk,
  input  logic rstn,
  input  logic f_zero,
  input  logic f_period,
  input  logic slope,
  output logic ev_c
);

  logic f_zero_q;
  logic f_period_q;

  // Previous-cycle flag levels for edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      f_zero_q   <= 1'b0;
      f_period_q <= 1'b0;
    end else begin
      f_zero_q   <= f_zero;
      f_period_q <= f_period;
    end
  end

  assign ev_c = (f_zero & ~f_zero_q) | (slope & f_period & ~f_period_q);

endmodule

// File: rtl/pwm_shadow_loader.sv
// Shadow-register loader: accepts set-points and applies them on carrier boundaries.
module pwm_shadow_loader
  import pwm_pkg::*;
#(
  parameter word_t PERIOD_RST = 32'd999,
  parameter word_t DT_RST     = 32'd10,
  parameter word_t DT_MAX     = 32'd255,
  parameter word_t PERIOD_MIN = 32'd16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PWM_W-1:0] s_period,
  input  logic [PWM_W-1:0] s_duty,
  input  logic [PWM_W-1:0] s_dead_time,
  input  logic [PWM_W-1:0] step_max,
  input  logic             force_load,
  input  logic             slope,
  input  logic             f_zero,
  input  logic             f_period,
  output logic [PWM_W-1:0] period,
  output logic [PWM_W-1:0] duty_cycle,
  output logic [PWM_W-1:0] dead_time,
  output logic             loaded,
  output logic             clamped,
  output logic             rejected
);

  state_t    state_q, state_d;
  setpoint_t tgt_q, tgt_d;
  word_t     period_d, duty_d, dt_d, duty_nxt;
  logic      loaded_d, clamped_d, rejected_d, s_ready_d;
  logic      ev;

  carrier_event_detect u_ev (
    .clk      (clk),
    .rstn     (rstn),
    .f_zero   (f_zero),
    .f_period (f_period),
    .slope    (slope),
    .ev_c     (ev)
  );

  // State, shadow and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      tgt_q      <= '{period: PERIOD_RST, duty: '0, dt: DT_RST};
      period     <= PERIOD_RST;
      duty_cycle <= '0;
      dead_time  <= DT_RST;
      loaded     <= 1'b0;
      clamped    <= 1'b0;
      rejected   <= 1'b0;
      s_ready    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      period     <= period_d;
      duty_cycle <= duty_d;
      dead_time  <= dt_d;
      loaded     <= loaded_d;
      clamped    <= clamped_d;
      rejected   <= rejected_d;
      s_ready    <= s_ready_d;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    period_d   = period;
    duty_d     = duty_cycle;
    dt_d       = dead_time;
    loaded_d   = 1'b0;
    clamped_d  = clamped;
    rejected_d = 1'b0;
    duty_nxt   = slew_step(duty_cycle, tgt_q.duty, step_max);

    case (state_q)
      IDLE: begin
        if (s_valid && s_ready) begin
          if (s_period < PERIOD_MIN) begin
            rejected_d = 1'b1;
          end else begin
            tgt_d.period = s_period;
            tgt_d.duty   = (s_duty > s_period) ? s_period : s_duty;
            tgt_d.dt     = (s_dead_time > DT_MAX) ? DT_MAX : s_dead_time;
            clamped_d    = (s_duty > s_period) || (s_dead_time > DT_MAX);
            state_d      = PENDING;
          end
        end
      end
      PENDING, SLEW: begin
        if (force_load) begin
          period_d = tgt_q.period;
          duty_d   = tgt_q.duty;
          dt_d     = tgt_q.dt;
          loaded_d = 1'b1;
          state_d  = IDLE;
        end else if (ev) begin
          period_d = tgt_q.period;
          dt_d     = tgt_q.dt;
          duty_d   = duty_nxt;
          if (duty_nxt == tgt_q.duty) begin
            loaded_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = SLEW;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_pwm_shadow_loader.sv
// Scoreboard bench for pwm_shadow_loader.
module tb_pwm_shadow_loader;

  logic        clk = 1'b0;
  logic        rstn, s_valid, s_ready, force_load, slope, f_zero, f_period;
  logic [31:0] s_period, s_duty, s_dead_time, step_max;
  logic [31:0] period, duty_cycle, dead_time;
  logic        loaded, clamped, rejected;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] duty;
    logic [31:0] dt;
    logic        loaded;
  } obs_t;

  obs_t exp_q[$];
  obs_t e, o;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwm_shadow_loader dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
    .s_period(s_period), .s_duty(s_duty), .s_dead_time(s_dead_time),
    .step_max(step_max), .force_load(force_load), .slope(slope),
    .f_zero(f_zero), .f_period(f_period), .period(period),
    .duty_cycle(duty_cycle), .dead_time(dead_time), .loaded(loaded),
    .clamped(clamped), .rejected(rejected)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] d, input logic [31:0] t);
    s_period = p; s_duty = d; s_dead_time = t; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_zero();
    f_zero = 1'b1; tick(); f_zero = 1'b0;
  endtask

  task automatic pulse_period();
    f_period = 1'b1; tick(); f_period = 1'b0;
  endtask

  task automatic pop_obs(input string name);
    o = '{period, duty_cycle, dead_time, loaded};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty, observed %0d/%0d/%0d/%0b", name, o.period, o.duty, o.dt, o.loaded);
    end else begin
      e = exp_q.pop_front();
      if (o !== e) begin
        failures++;
        $display("FAIL %s: got %0d/%0d/%0d/%0b required %0d/%0d/%0d/%0b",
                 name, o.period, o.duty, o.dt, o.loaded, e.period, e.duty, e.dt, e.loaded);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; tick(3); rstn = 1'b1; tick();
    exp_q.push_back('{32'd999, 32'd0, 32'd10, 1'b0});
    pop_obs("reset_outputs");
    checks++;
    if ({s_ready, clamped, rejected} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags: got ready/clamped/rejected=%b required 100", {s_ready, clamped, rejected});
    end
  endtask

  task automatic test_step_load();
    slope = 1'b0; step_max = 0;
    // transfer coincides with an f_zero rise: must wait for the next one
    s_period = 1000; s_duty = 400; s_dead_time = 20; s_valid = 1'b1; f_zero = 1'b1;
    tick(); s_valid = 1'b0;
    exp_q.push_back('{32'd999, 32'd0, 32'd10, 1'b0});
    exp_q.push_back('{32'd1000, 32'd400, 32'd20, 1'b1});
    tick(); f_zero = 1'b0; tick(2);
    pop_obs("step_unchanged_before_ev");
    checks++;
    if (s_ready !== 1'b0) begin
      failures++;
      $display("FAIL step_ready_low: got %b required 0", s_ready);
    end
    pulse_zero();
    pop_obs("step_applied");
    tick();
    checks++;
    if ({loaded, s_ready} !== 2'b01) begin
      failures++;
      $display("FAIL step_after: got loaded/ready=%b required 01", {loaded, s_ready});
    end
  endtask

  task automatic test_slew();
    slope = 1'b0; step_max = 0;
    send(1000, 100, 20); pulse_zero(); tick();
    slope = 1'b1; step_max = 100;
    send(1000, 450, 20);
    exp_q.push_back('{32'd1000, 32'd200, 32'd20, 1'b0});
    exp_q.push_back('{32'd1000, 32'd300, 32'd20, 1'b0});
    exp_q.push_back('{32'd1000, 32'd400, 32'd20, 1'b0});
    exp_q.push_back('{32'd1000, 32'd450, 32'd20, 1'b1});
    exp_q.delete(0);
    exp_q.push_front('{32'd1000, 32'd200, 32'd20, 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick(2);
      if (i % 2 == 0) pulse_zero(); else pulse_period();
      pop_obs($sformatf("slew_step%0d", i));
    end
    tick();
    slope = 1'b0;
  endtask

  task automatic test_clamp();
    step_max = 0;
    send(500, 800, 300);
    checks++;
    if (clamped !== 1'b1) begin
      failures++;
      $display("FAIL clamp_set: got %b required 1", clamped);
    end
    exp_q.push_back('{32'd500, 32'd500, 32'd255, 1'b1});
    pulse_zero(); pop_obs("clamp_applied"); tick();
    send(1000, 300, 20);
    checks++;
    if (clamped !== 1'b0) begin
      failures++;
      $display("FAIL clamp_clear: got %b required 0", clamped);
    end
    exp_q.push_back('{32'd1000, 32'd300, 32'd20, 1'b1});
    pulse_zero(); pop_obs("clamp_clear_applied"); tick();
  endtask

  task automatic test_reject();
    send(8, 100, 5);
    checks++;
    if ({rejected, s_ready} !== 2'b11) begin
      failures++;
      $display("FAIL reject_pulse: got rejected/ready=%b required 11", {rejected, s_ready});
    end
    tick();
    checks++;
    if (rejected !== 1'b0) begin
      failures++;
      $display("FAIL reject_one_cycle: got %b required 0", rejected);
    end
    exp_q.push_back('{32'd1000, 32'd300, 32'd20, 1'b0});
    pulse_zero(); pop_obs("reject_outputs_unchanged"); tick();
    send(15, 10, 5);
    checks++;
    if (rejected !== 1'b1) begin
      failures++;
      $display("FAIL reject_15: got %b required 1", rejected);
    end
    tick();
    send(16, 20, 5);
    exp_q.push_back('{32'd16, 32'd16, 32'd5, 1'b1});
    pulse_zero(); pop_obs("accept_16_clamped");
    tick();
  endtask

  task automatic test_force();
    slope = 1'b0; step_max = 0;
    send(1000, 100, 20); pulse_zero(); tick();
    step_max = 100;
    send(1000, 450, 20);
    f_zero = 1'b1; tick(2); f_zero = 1'b0;
    exp_q.push_back('{32'd1000, 32'd200, 32'd20, 1'b0});
    exp_q.push_back('{32'd1000, 32'd200, 32'd20, 1'b0});
    exp_q.push_back('{32'd1000, 32'd450, 32'd20, 1'b1});
    pop_obs("force_held_zero_single_step");
    tick(); pulse_period();
    pop_obs("force_sawtooth_ignores_f_period");
    force_load = 1'b1; tick(); force_load = 1'b0;
    pop_obs("force_applied");
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL force_idle: got ready=%b required 1", s_ready);
    end
    tick();
    force_load = 1'b1; tick(); force_load = 1'b0;
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL force_in_idle: got loaded=%b required 0", loaded);
    end
  endtask

  task automatic test_reset_discard();
    step_max = 0;
    send(1000, 700, 30);
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
    exp_q.push_back('{32'd999, 32'd0, 32'd10, 1'b0});
    pulse_zero(); pop_obs("reset_discards_pending");
    tick();
  endtask

  initial begin
    rstn = 1'b0; s_valid = 1'b0; force_load = 1'b0; slope = 1'b0;
    f_zero = 1'b0; f_period = 1'b0;
    s_period = 0; s_duty = 0; s_dead_time = 0; step_max = 0;
    test_reset();
    test_step_load();
    test_slew();
    test_clamp();
    test_reject();
    test_force();
    test_reset_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
